// File: rtl/md_feed_decoder.sv
// md_feed_decoder: turns the exchange byte stream into single-cycle
// top-of-book updates. Each 11-byte frame (sync, type, price, size, XOR)
// is validated; bad, corrupted, stalled or sentinel-priced frames are
// dropped and counted so they never reach the book.
module md_feed_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        valid_out,
  output logic [31:0] price_out,
  output logic [31:0] size_out,
  output logic        side_out,
  output logic [15:0] frame_cnt,
  output logic [15:0] chk_err_cnt,
  output logic [15:0] bad_msg_cnt,
  output logic [15:0] timeout_cnt
);

  typedef enum logic [1:0] {HUNT, TYPE, BODY, CHK} state_t;

  localparam logic [7:0]  TYPE_BID  = 8'h42;
  localparam logic [7:0]  TYPE_ASK  = 8'h53;
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state;
  logic [3:0]  idx;
  logic [63:0] shreg;
  logic [7:0]  xor_r;
  logic        side_r;
  logic [15:0] idle_cnt;
  logic        pend_valid;
  logic        accept;
  logic [31:0] cur_price;
  logic [31:0] cur_size;

  assign accept    = s_valid && s_ready;
  assign cur_price = shreg[63:32];
  assign cur_size  = shreg[31:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // Frame FSM, idle timeout, error counters and registered book update.
  // A good frame is flagged on the edge accepting the checksum and
  // presented on the following edge; the shift register is untouched
  // while the next frame's sync/type bytes arrive, so it is read directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      shreg       <= '0;
      xor_r       <= '0;
      side_r      <= 1'b0;
      idle_cnt    <= '0;
      pend_valid  <= 1'b0;
      s_ready     <= 1'b0;
      valid_out   <= 1'b0;
      price_out   <= '0;
      size_out    <= '0;
      side_out    <= 1'b0;
      frame_cnt   <= '0;
      chk_err_cnt <= '0;
      bad_msg_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      s_ready    <= 1'b1;
      valid_out  <= pend_valid;
      pend_valid <= 1'b0;
      if (pend_valid) begin
        price_out <= cur_price;
        size_out  <= cur_size;
        side_out  <= side_r;
        frame_cnt <= sat_inc(frame_cnt);
      end

      if (state == HUNT) begin
        idle_cnt <= '0;
        if (accept && s_data == SYNC_BYTE) state <= TYPE;
      end else if (accept) begin
        idle_cnt <= '0;
        case (state)
          TYPE: begin
            if (s_data == TYPE_BID || s_data == TYPE_ASK) begin
              side_r <= (s_data == TYPE_ASK);
              xor_r  <= s_data;
              idx    <= '0;
              state  <= BODY;
            end else begin
              bad_msg_cnt <= sat_inc(bad_msg_cnt);
              state       <= HUNT;
            end
          end
          BODY: begin
            shreg <= {shreg[55:0], s_data};
            xor_r <= xor_r ^ s_data;
            idx   <= idx + 4'd1;
            if (idx == 4'd7) state <= CHK;
          end
          CHK: begin
            if (xor_r != s_data)
              chk_err_cnt <= sat_inc(chk_err_cnt);
            else if (cur_price == '0 || cur_price == '1)
              bad_msg_cnt <= sat_inc(bad_msg_cnt);
            else
              pend_valid <= 1'b1;
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (idle_cnt == IDLE_LAST) begin
        idle_cnt    <= '0;
        timeout_cnt <= sat_inc(timeout_cnt);
        state       <= HUNT;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_feed_decoder.sv
// Directed bench for md_feed_decoder with TIMEOUT_CYCLES = 16.
module tb_md_feed_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        valid_out;
  logic [31:0] price_out;
  logic [31:0] size_out;
  logic        side_out;
  logic [15:0] frame_cnt;
  logic [15:0] chk_err_cnt;
  logic [15:0] bad_msg_cnt;
  logic [15:0] timeout_cnt;

  md_feed_decoder #(
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .valid_out(valid_out),
    .price_out(price_out),
    .size_out(size_out),
    .side_out(side_out),
    .frame_cnt(frame_cnt),
    .chk_err_cnt(chk_err_cnt),
    .bad_msg_cnt(bad_msg_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every update strobe seen at the falling edge.
  int          pulses = 0;
  int          pulse_cyc[$];
  logic [31:0] pprice[$];
  logic [31:0] psize[$];
  logic        pside[$];
  always @(negedge clk) begin
    if (valid_out) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      pprice.push_back(price_out);
      psize.push_back(size_out);
      pside.push_back(side_out);
    end
  end

  int         last_acc = 0;
  logic [7:0] fr [11];

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) check("s_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic mk(input logic [7:0] typ, input logic [31:0] price,
                    input logic [31:0] size, input logic [7:0] cs_flip);
    logic [7:0] cs;
    fr[0] = 8'hA5;
    fr[1] = typ;
    for (int i = 0; i < 4; i++) begin
      fr[2 + i] = price[31 - 8*i -: 8];
      fr[6 + i] = size[31 - 8*i -: 8];
    end
    cs = '0;
    for (int i = 1; i < 10; i++) cs = cs ^ fr[i];
    fr[10] = cs ^ cs_flip;
  endtask

  task automatic send_frame(input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i < 11; i++) begin
      if (i == gap_at) idle(gap_len);
      if (rnd) begin
        int g;
        g = int'($urandom_range(0, 3));
        if (g > 0) idle(g);
      end
      put_byte(fr[i]);
    end
  endtask

  task automatic check_last(input string tag, input logic [31:0] price,
                            input logic [31:0] size, input logic side);
    if (pprice.size() == 0) begin
      check({tag, "_none"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_price"}, pprice[$], price);
      check({tag, "_size"},  psize[$],  size);
      check({tag, "_side"},  {31'd0, pside[$]}, {31'd0, side});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_price"}, price_out, 32'd0);
    check({tag, "_size"},  size_out,  32'd0);
    check({tag, "_side"},  {31'd0, side_out}, 32'd0);
    check({tag, "_fcnt"},  {16'd0, frame_cnt},   32'd0);
    check({tag, "_ccnt"},  {16'd0, chk_err_cnt}, 32'd0);
    check({tag, "_bcnt"},  {16'd0, bad_msg_cnt}, 32'd0);
    check({tag, "_tcnt"},  {16'd0, timeout_cnt}, 32'd0);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
  endtask

  int exp_p = 0;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_zero("rst");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, s_ready}, 32'd1);

    // Bid 10000 x 100; strobe one edge after checksum byte.
    mk(8'h42, 32'd10000, 32'd100, 8'h00);
    check("cs_t1", {24'd0, fr[10]}, 32'h11);
    send_frame(-1, 0, 1'b0);
    s_valid = 1'b0;
    check("t1_no_early", {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    check("t1_valid", {31'd0, valid_out}, 32'd1);
    check("t1_fcnt", {16'd0, frame_cnt}, 32'd1);
    idle(2);
    exp_p = 1;
    check("t1_pulses", pulses, exp_p);
    check_last("t1", 32'd10000, 32'd100, 1'b0);
    if (pulse_cyc.size() > 0) check("t1_lat", pulse_cyc[$] - last_acc, 32'd1);
    check("t1_hold_price", price_out, 32'd10000);

    // Corrupted checksum, then good ask 10100 x 250.
    mk(8'h42, 32'd10000, 32'd100, 8'h01);
    send_frame(-1, 0, 1'b0);
    idle(2);
    check("t2_pulses", pulses, exp_p);
    check("t2_ccnt", {16'd0, chk_err_cnt}, 32'd1);
    mk(8'h53, 32'd10100, 32'd250, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p++;
    check("t2b_pulses", pulses, exp_p);
    check_last("t2b", 32'd10100, 32'd250, 1'b1);

    // Bad type byte, then a good bid.
    put_byte(8'hA5);
    put_byte(8'h11);
    mk(8'h42, 32'd9999, 32'd7, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p++;
    check("t3_bcnt", {16'd0, bad_msg_cnt}, 32'd1);
    check("t3_pulses", pulses, exp_p);
    check_last("t3", 32'd9999, 32'd7, 1'b0);

    // Sentinel prices with valid checksums.
    mk(8'h42, 32'hFFFF_FFFF, 32'd100, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    check("t3_ones_bcnt", {16'd0, bad_msg_cnt}, 32'd2);
    check("t3_ones_pulses", pulses, exp_p);
    mk(8'h53, 32'd0, 32'd100, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    check("t3_zero_bcnt", {16'd0, bad_msg_cnt}, 32'd3);
    check("t3_zero_pulses", pulses, exp_p);

    // Checksum byte equal to sync, immediately followed by a frame.
    mk(8'h42, 32'h0000_00E7, 32'd0, 8'h00);
    check("cs_sync", {24'd0, fr[10]}, 32'hA5);
    send_frame(-1, 0, 1'b0);
    mk(8'h53, 32'd500, 32'd9, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p += 2;
    check("t_cs_sync_pulses", pulses, exp_p);
    check("t_cs_sync_bcnt", {16'd0, bad_msg_cnt}, 32'd3);
    check_last("t_cs_sync", 32'd500, 32'd9, 1'b1);

    // Timeout: idle exactly 16 cycles after byte 2.
    put_byte(8'hA5);
    put_byte(8'h42);
    put_byte(8'h00);
    idle(15);
    check("t4_no_to_yet", {16'd0, timeout_cnt}, 32'd0);
    idle(1);
    check("t4_tcnt", {16'd0, timeout_cnt}, 32'd1);
    mk(8'h42, 32'd10000, 32'd100, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p++;
    check("t4_after_pulses", pulses, exp_p);
    // 15-cycle stall is tolerated.
    mk(8'h53, 32'd10100, 32'd250, 8'h00);
    send_frame(3, 15, 1'b0);
    idle(2);
    exp_p++;
    check("t4_stall_pulses", pulses, exp_p);
    check("t4_stall_tcnt", {16'd0, timeout_cnt}, 32'd1);
    check_last("t4_stall", 32'd10100, 32'd250, 1'b1);

    // Back-to-back frames with s_valid held high.
    mk(8'h42, 32'd10000, 32'd100, 8'h00);
    send_frame(-1, 0, 1'b0);
    mk(8'h53, 32'd10100, 32'd250, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p += 2;
    check("t5_pulses", pulses, exp_p);
    if (pulse_cyc.size() >= 2)
      check("t5_spacing", pulse_cyc[$] - pulse_cyc[$-1], 32'd11);
    if (pprice.size() >= 2) check("t5_first_price", pprice[$-1], 32'd10000);
    check_last("t5", 32'd10100, 32'd250, 1'b1);

    // Same frames with random valid gaps.
    mk(8'h42, 32'd10000, 32'd100, 8'h00);
    send_frame(-1, 0, 1'b1);
    idle(2);
    check_last("t5r_a", 32'd10000, 32'd100, 1'b0);
    mk(8'h53, 32'd10100, 32'd250, 8'h00);
    send_frame(-1, 0, 1'b1);
    idle(2);
    exp_p += 2;
    check("t5r_pulses", pulses, exp_p);
    check_last("t5r_b", 32'd10100, 32'd250, 1'b1);
    check("t5r_fcnt", {16'd0, frame_cnt}, 32'd11);

    // Reset mid-frame after byte 6.
    mk(8'h42, 32'd10000, 32'd100, 8'h00);
    for (int i = 0; i < 6; i++) put_byte(fr[i]);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 6; i < 11; i++) put_byte(fr[i]);
    mk(8'h53, 32'd4242, 32'd17, 8'h00);
    send_frame(-1, 0, 1'b0);
    idle(2);
    exp_p++;
    check("t6_pulses", pulses, exp_p);
    check_last("t6", 32'd4242, 32'd17, 1'b1);
    check("t6_fcnt", {16'd0, frame_cnt},   32'd1);
    check("t6_ccnt", {16'd0, chk_err_cnt}, 32'd0);
    check("t6_bcnt", {16'd0, bad_msg_cnt}, 32'd0);
    check("t6_tcnt", {16'd0, timeout_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
